// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: shared types and constants for the bit-serial compare
// sequencer.
//   state_e        : sequencer FSM states (2-bit encoding)
//   RES_GT/EQ/LT   : one-hot {gt, eq, lt} result encodings
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/bit_serial_cmp.sv
// bit_serial_cmp: sticky MSB-first magnitude compare, one bit pair per clock.
//   clk    in  : rising-edge clock
//   reset  in  : synchronous, active-high; clears to G=0, E=1, L=0
//   a_bit  in  : current bit of operand A
//   b_bit  in  : current bit of operand B
//   G/E/L  out : A greater / equal so far / A less
module bit_serial_cmp (
    input  logic clk,
    input  logic reset,
    input  logic a_bit,
    input  logic b_bit,
    output logic G,
    output logic E,
    output logic L
);

    logic g_q, e_q, l_q;

    // Only the first differing bit can set G or L; once E drops the result
    // is frozen regardless of later bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_q <= 1'b0;
            e_q <= 1'b1;
            l_q <= 1'b0;
        end else begin
            g_q <= g_q | (e_q & a_bit & ~b_bit);
            l_q <= l_q | (e_q & ~a_bit & b_bit);
            e_q <= e_q & (a_bit == b_bit);
        end
    end

    assign G = g_q;
    assign E = e_q;
    assign L = l_q;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl: sequencer feeding two parallel operands MSB-first into a
// bit-serial comparator and reporting the result with a one-cycle done pulse.
//   clk       in  : rising-edge clock
//   reset     in  : synchronous, active-high; aborts any compare
//   start     in  : request, sampled only in IDLE
//   a_in/b_in in  : operands, captured when start is accepted
//   busy      out : high in CLEAR, SHIFT and DONE
//   done      out : one-cycle pulse, result valid
//   gt/eq/lt  out : one-hot result, held until the next done
//   diff_idx  out : index of the most-significant differing bit (0 if equal)
module serial_cmp_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1,
    parameter int IDXW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [IDXW-1:0]  diff_idx
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [IDXW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [2:0]        res_q, res_d;
    logic [IDXW-1:0]   hidx_q, hidx_d;

    logic core_rst, core_g, core_e, core_l;

    // Core is kept cleared while reset is held and for the CLEAR cycle.
    assign core_rst = reset | (state_q == CLEAR);

    bit_serial_cmp u_core (
        .clk   (clk),
        .reset (core_rst),
        .a_bit (a_sh_q[WIDTH-1]),
        .b_bit (b_sh_q[WIDTH-1]),
        .G     (core_g),
        .E     (core_e),
        .L     (core_l)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            hidx_q  <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            hidx_q  <= hidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        res_d   = res_q;
        hidx_d  = hidx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    cnt_d   = IDXW'(WIDTH - 1);
                    idx_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: state_d = SHIFT;
            SHIFT: begin
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q << 1;
                cnt_d  = cnt_q - IDXW'(1);
                // cnt equals the bit index of the pair being presented now.
                if (core_e && (a_sh_q[WIDTH-1] != b_sh_q[WIDTH-1]))
                    idx_d = cnt_q;
                if ((cnt_q == '0) || (EARLY_EXIT && (core_g || core_l)))
                    state_d = DONE;
            end
            DONE: begin
                res_d   = {core_g, core_e, core_l};
                hidx_d  = idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign {gt, eq, lt} = done ? {core_g, core_e, core_l} : res_q;
    assign diff_idx     = done ? idx_q : hidx_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
module tb_serial_cmp_ctrl;
    import serial_cmp_pkg::*;

    logic       clk = 1'b0;
    logic       reset, start0, start1;
    logic [7:0] a_in, b_in;
    logic       busy0, done0, gt0, eq0, lt0;
    logic       busy1, done1, gt1, eq1, lt1;
    logic [2:0] idx0, idx1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Full-scan instance and early-exit instance share operands.
    serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .a_in(a_in), .b_in(b_in),
        .busy(busy0), .done(done0), .gt(gt0), .eq(eq0), .lt(lt0), .diff_idx(idx0));

    serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a_in(a_in), .b_in(b_in),
        .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1), .diff_idx(idx1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] res;
        logic [2:0] idx;
        int         c0;   // done cycle, full scan
        int         c1;   // done cycle, early exit
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] er, input logic [2:0] ei,
                          input int ec0, input int ec1);
        int dc0, dc1, nd0, nd1, bb0, bb1;
        logic [2:0] r0, r1, i0, i1;
        dc0 = -1; dc1 = -1; nd0 = 0; nd1 = 0; bb0 = 0; bb1 = 0;
        r0 = '0; r1 = '0; i0 = '0; i1 = '0;
        a_in = a; b_in = b; start0 = 1'b1; start1 = 1'b1;
        step();
        // Cycle 1: drop start and disturb operands; must not matter.
        start0 = 1'b0; start1 = 1'b0; a_in = ~a; b_in = ~b;
        for (int c = 1; c <= 15; c++) begin
            if (done0) begin nd0++; dc0 = c; r0 = {gt0, eq0, lt0}; i0 = idx0; end
            if (done1) begin nd1++; dc1 = c; r1 = {gt1, eq1, lt1}; i1 = idx1; end
            if (busy0 !== (c <= ec0)) bb0++;
            if (busy1 !== (c <= ec1)) bb1++;
            step();
        end
        chk({tag, "_cyc_full"},  dc0, ec0);
        chk({tag, "_res_full"},  r0,  er);
        chk({tag, "_idx_full"},  i0,  ei);
        chk({tag, "_ndone_full"}, nd0, 1);
        chk({tag, "_busy_full"}, bb0, 0);
        chk({tag, "_hold_full"}, {gt0, eq0, lt0, idx0}, {er, ei});
        chk({tag, "_cyc_ee"},    dc1, ec1);
        chk({tag, "_res_ee"},    r1,  er);
        chk({tag, "_idx_ee"},    i1,  ei);
        chk({tag, "_ndone_ee"},  nd1, 1);
        chk({tag, "_busy_ee"},   bb1, 0);
        chk({tag, "_hold_ee"},   {gt1, eq1, lt1, idx1}, {er, ei});
    endtask

    initial begin
        int nd, d1c, d2c, b11, b12;
        logic [2:0] r1, r2, i1, i2;

        vecs[0] = '{8'hA5, 8'hA5, RES_EQ, 3'd0, 10, 10};
        vecs[1] = '{8'h80, 8'h7F, RES_GT, 3'd7, 10, 4};
        vecs[2] = '{8'h12, 8'h13, RES_LT, 3'd0, 10, 10};
        vecs[3] = '{8'h40, 8'h00, RES_GT, 3'd6, 10, 5};
        vecs[4] = '{8'h01, 8'h02, RES_LT, 3'd1, 10, 10};
        vecs[5] = '{8'hFF, 8'h00, RES_GT, 3'd7, 10, 4};
        vecs[6] = '{8'h00, 8'h80, RES_LT, 3'd7, 10, 4};
        vecs[7] = '{8'h3C, 8'h34, RES_GT, 3'd3, 10, 8};

        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; a_in = '0; b_in = '0;
        step(); step();
        chk("rst_out_full", {busy0, done0, gt0, eq0, lt0, idx0}, 0);
        chk("rst_out_ee",   {busy1, done1, gt1, eq1, lt1, idx1}, 0);
        reset = 1'b0;
        step();
        chk("idle_out_full", {busy0, done0, gt0, eq0, lt0, idx0}, 0);
        chk("idle_out_ee",   {busy1, done1, gt1, eq1, lt1, idx1}, 0);

        for (int k = 0; k < 8; k++)
            run_op($sformatf("v%0d", k), vecs[k].a, vecs[k].b, vecs[k].res,
                   vecs[k].idx, vecs[k].c0, vecs[k].c1);

        // Result holds through subsequent IDLE cycles.
        run_op("hold", 8'h12, 8'h13, RES_LT, 3'd0, 10, 10);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("hold_c%0d_full", c), {done0, gt0, eq0, lt0, idx0}, {1'b0, RES_LT, 3'd0});
            chk($sformatf("hold_c%0d_ee", c),   {done1, gt1, eq1, lt1, idx1}, {1'b0, RES_LT, 3'd0});
        end

        // Starts during CLEAR/SHIFT/DONE are ignored; start in first IDLE accepted.
        nd = 0; d1c = -1; d2c = -1; b11 = -1; b12 = -1;
        r1 = '0; r2 = '0; i1 = '0; i2 = '0;
        a_in = 8'h40; b_in = 8'h00; start0 = 1'b1;
        step();
        start0 = 1'b0; a_in = 8'h00; b_in = 8'hFF;
        for (int c = 1; c <= 23; c++) begin
            start0 = (c == 3) || (c == 10) || (c == 11);
            if (done0) begin
                nd++;
                if (nd == 1) begin d1c = c; r1 = {gt0, eq0, lt0}; i1 = idx0; end
                else begin d2c = c; r2 = {gt0, eq0, lt0}; i2 = idx0; end
            end
            if (c == 11) b11 = busy0;
            if (c == 12) b12 = busy0;
            step();
        end
        start0 = 1'b0;
        chk("ign_ndone",   nd,  2);
        chk("ign_cyc1",    d1c, 10);
        chk("ign_res1",    r1,  RES_GT);
        chk("ign_idx1",    i1,  6);
        chk("ign_busy_c11", b11, 0);
        chk("ign_busy_c12", b12, 1);
        chk("ign_cyc2",    d2c, 21);
        chk("ign_res2",    r2,  RES_LT);
        chk("ign_idx2",    i2,  7);

        // Reset mid-SHIFT discards the compare.
        a_in = 8'h01; b_in = 8'h00; start0 = 1'b1; start1 = 1'b1;
        step();
        start0 = 1'b0; start1 = 1'b0;
        for (int c = 1; c < 5; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_full", {busy0, done0, gt0, eq0, lt0, idx0}, 0);
        chk("midrst_ee",   {busy1, done1, gt1, eq1, lt1, idx1}, 0);
        nd = 0;
        for (int c = 6; c <= 14; c++) begin
            if (done0 || done1 || busy0 || busy1) nd++;
            step();
        end
        chk("midrst_quiet", nd, 0);
        run_op("post_rst", 8'h01, 8'h02, RES_LT, 3'd1, 10, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
